// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions. The state encodings are common to
//                the transmitter and the matching receiver so both ends of
//                the link decode the same values.
//                Contents: FSM state encodings, frame constants, byte type.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // FSM state encodings shared by uart_tx and uart_rx
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // Frame format: 8N1
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef logic [DATA_BITS-1:0] uart_byte_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_if
//  Description : Byte handshake between host logic and the UART transmitter.
//                Ports (signals):
//                  i_Tx_Valid - host presents a byte
//                  i_Tx_Data  - byte to send
//                  o_Tx_Ready - transmitter queue can accept a byte
//                Modports: master (host side), slave (transmitter side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
    import uart_pkg::*;

    logic       i_Tx_Valid;
    uart_byte_t i_Tx_Data;
    logic       o_Tx_Ready;

    modport master (output i_Tx_Valid, output i_Tx_Data, input  o_Tx_Ready);
    modport slave  (input  i_Tx_Valid, input  i_Tx_Data, output o_Tx_Ready);

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Synchronous first-word-fall-through byte FIFO.
//                Ports:
//                  clk, rst_n - clock, async active-low reset
//                  push, din  - write strobe and data (ignored when full)
//                  pop        - remove head (ignored when empty)
//                  dout       - current head entry
//                  full/empty - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic push,
    input  uart_byte_t din,
    input  wire logic pop,
    output uart_byte_t dout,
    output logic      full,
    output logic      empty
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    uart_byte_t      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign full   = (r_count == c_CW'(FIFO_DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter with an input byte queue.
//                Ports:
//                  clk, rst_n   - clock, async active-low reset
//                  tx_bus       - valid/ready byte handshake (slave)
//                  o_Tx_Serial  - registered serial line, idles high
//                  o_Tx_Active  - high while a frame is on the line
//                  o_Tx_Done    - pulse on the last clock of each stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    uart_tx_if.slave   tx_bus,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam logic [15:0] c_CNT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  c_DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]  c_STOP_LAST = 3'(STOP_BITS - 1);

    logic [1:0]  r_state;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_idx;
    uart_byte_t  r_shift;
    logic        r_serial;
    logic        r_active;
    logic        r_done;

    uart_byte_t  w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_bit_last;
    logic        w_frame_end;

    assign w_push      = tx_bus.i_Tx_Valid && !w_full;
    assign tx_bus.o_Tx_Ready = !w_full;
    assign w_bit_last  = (r_clk_cnt == c_CNT_LAST);
    assign w_frame_end = (r_state == STOP) && w_bit_last && (r_bit_idx == c_STOP_LAST);
    // Pop from idle, or at the end of a stop bit so the next frame follows
    // with no idle clock in between.
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_frame_end);

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (tx_bus.i_Tx_Data),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_last) begin
                        r_clk_cnt <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (w_bit_last) begin
                        r_clk_cnt <= '0;
                        r_shift   <= r_shift >> 1;
                        if (r_bit_idx == c_DATA_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (w_bit_last) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == c_STOP_LAST) begin
                            r_bit_idx <= '0;
                            if (!w_empty) begin
                                r_shift <= w_head;
                                r_state <= START;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                end
            endcase
        end
    end

    // Line, active and done are all registered from the current state, so
    // the three outputs stay mutually aligned one clock behind the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_serial <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                START:   r_serial <= 1'b0;
                DATA:    r_serial <= r_shift[0];
                default: r_serial <= 1'b1;
            endcase
            r_active <= (r_state == START) || (r_state == DATA) || (r_state == STOP);
            r_done   <= w_frame_end;
        end
    end

    assign o_Tx_Serial = r_serial;
    assign o_Tx_Active = r_active;
    assign o_Tx_Done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. Two instances: A with
//                CLKS_PER_BIT=4, B with CLKS_PER_BIT=2 (both FIFO_DEPTH=4).
//                Stimulus queues expected bytes; per-instance monitors decode
//                frames on the line and compare against those queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
    import uart_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    uart_tx_if bus_a ();
    uart_tx_if bus_b ();

    logic ser_a, act_a, done_a;
    logic ser_b, act_b, done_b;

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_bus      (bus_a),
        .o_Tx_Serial (ser_a),
        .o_Tx_Active (act_a),
        .o_Tx_Done   (done_a)
    );

    uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_bus      (bus_b),
        .o_Tx_Serial (ser_b),
        .o_Tx_Active (act_b),
        .o_Tx_Done   (done_b)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    bit         busy[2];
    int         mon_idx[2];

    function automatic void chk(input string name, input int act, input int req);
        n_total++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic int qsize(input int m);
        return (m == 0) ? exp_a.size() : exp_b.size();
    endfunction

    // Frame monitor: samples on the falling edge, one sample per clock.
    task automatic monitor(input int m, input int cpb);
        int         idx;
        int         b;
        bit         inf;
        logic [7:0] cur;
        logic       s, a, d, r, e;
        idx = 0;
        inf = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            s = (m == 0) ? ser_a  : ser_b;
            a = (m == 0) ? act_a  : act_b;
            d = (m == 0) ? done_a : done_b;
            r = (m == 0) ? bus_a.o_Tx_Ready : bus_b.o_Tx_Ready;
            if (!rst_n) begin
                chk($sformatf("rst_serial_%0d", m), int'(s), 1);
                chk($sformatf("rst_active_%0d", m), int'(a), 0);
                chk($sformatf("rst_done_%0d", m),   int'(d), 0);
                chk($sformatf("rst_ready_%0d", m),  int'(r), 1);
                inf = 0;
                idx = 0;
                if (m == 0) exp_a.delete();
                else        exp_b.delete();
            end else begin
                if (!inf) begin
                    if (s == 1'b0) begin
                        if (qsize(m) > 0) begin
                            cur = (m == 0) ? exp_a.pop_front() : exp_b.pop_front();
                            inf = 1;
                            idx = 0;
                        end else begin
                            chk($sformatf("spurious_start_%0d", m), int'(s), 1);
                        end
                    end else begin
                        chk($sformatf("idle_active_%0d", m), int'(a), 0);
                        chk($sformatf("idle_done_%0d", m),   int'(d), 0);
                    end
                end
                if (inf) begin
                    b = idx / cpb;
                    if (b == 0)              e = 1'b0;
                    else if (b <= DATA_BITS) e = cur[b-1];
                    else                     e = 1'b1;
                    chk($sformatf("line_%0d_byte%02h_clk%0d", m, cur, idx), int'(s), int'(e));
                    chk($sformatf("active_%0d_clk%0d", m, idx), int'(a), 1);
                    chk($sformatf("done_%0d_clk%0d", m, idx), int'(d), (idx == 10*cpb-1) ? 1 : 0);
                    idx++;
                    if (idx == 10*cpb) inf = 0;
                end
            end
            busy[m]    = inf;
            mon_idx[m] = idx;
        end
    endtask

    initial monitor(0, 4);
    initial monitor(1, 2);

    task automatic send(input int m, input logic [7:0] b);
        if (m == 0) begin
            chk("send_ready_a", int'(bus_a.o_Tx_Ready), 1);
            bus_a.i_Tx_Valid = 1'b1;
            bus_a.i_Tx_Data  = b;
            exp_a.push_back(b);
        end else begin
            chk("send_ready_b", int'(bus_b.o_Tx_Ready), 1);
            bus_b.i_Tx_Valid = 1'b1;
            bus_b.i_Tx_Data  = b;
            exp_b.push_back(b);
        end
        @(posedge clk);
        #1;
        bus_a.i_Tx_Valid = 1'b0;
        bus_b.i_Tx_Valid = 1'b0;
    endtask

    task automatic wait_idle(input int m, input int budget);
        int k;
        k = 0;
        while ((busy[m] || qsize(m) > 0) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (busy[m] || qsize(m) > 0) begin
            n_total++;
            n_bad++;
            $display("FAIL timeout_idle_%0d: frames still pending after %0d clocks", m, budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   first, last, n_act, n_done, d0, d1, k;
        bit   exp_rdy[6];
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        bus_a.i_Tx_Valid = 1'b0;
        bus_a.i_Tx_Data  = '0;
        bus_b.i_Tx_Valid = 1'b0;
        bus_b.i_Tx_Data  = '0;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: monitors check line/active/done every clock.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_ready_a", int'(bus_a.o_Tx_Ready), 1);
            chk("idle_ready_b", int'(bus_b.o_Tx_Ready), 1);
        end
        @(posedge clk);
        #1;

        // Single byte 0xA5 with first-frame latency.
        send(0, 8'hA5);
        @(negedge clk); chk("latency_edgeN",  int'(ser_a), 1);
        @(negedge clk); chk("latency_edgeN1", int'(ser_a), 1);
        @(negedge clk); chk("latency_edgeN2", int'(ser_a), 0);
        wait_idle(0, 100);

        // Back-to-back 0x00, 0xFF.
        send(0, 8'h00);
        send(0, 8'hFF);
        first = -1; last = -1; n_act = 0; n_done = 0; d0 = -1; d1 = -1;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (act_a) begin
                if (first < 0) first = i;
                last = i;
                n_act++;
            end
            if (done_a) begin
                if (n_done == 0) d0 = i;
                else if (n_done == 1) d1 = i;
                n_done++;
            end
        end
        chk("b2b_active_count", n_act, 80);
        chk("b2b_active_span",  last - first + 1, 80);
        chk("b2b_done_count",   n_done, 2);
        chk("b2b_done_first",   d0 - first, 39);
        chk("b2b_done_second",  d1 - first, 79);
        wait_idle(0, 100);

        // Full queue: valid held 6 clocks with 0x01..0x06; 0x06 is refused.
        for (int i = 1; i <= 5; i++) exp_a.push_back(8'(i));
        for (int i = 0; i < 6; i++) begin
            bus_a.i_Tx_Valid = 1'b1;
            bus_a.i_Tx_Data  = 8'(i + 1);
            chk($sformatf("full_ready_cycle%0d", i), int'(bus_a.o_Tx_Ready), int'(exp_rdy[i]));
            @(posedge clk);
            #1;
        end
        bus_a.i_Tx_Valid = 1'b0;
        chk("full_ready_after", int'(bus_a.o_Tx_Ready), 0);
        wait_idle(0, 400);

        // Reset during data bit 3 of 0x3C with another byte still queued.
        send(0, 8'h3C);
        send(0, 8'h5A);
        k = 0;
        while (!(busy[0] && mon_idx[0] >= 18) && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!(busy[0] && mon_idx[0] >= 18)) begin
            n_total++;
            n_bad++;
            $display("FAIL timeout_reset_point: frame never reached data bit 3");
        end
        chk("pre_rst_active", int'(act_a), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_serial", int'(ser_a), 1);
        chk("async_rst_active", int'(act_a), 0);
        chk("async_rst_done",   int'(done_a), 0);
        chk("async_rst_ready",  int'(bus_a.o_Tx_Ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_rst_ready", int'(bus_a.o_Tx_Ready), 1);
        @(posedge clk);
        #1;

        // Minimum bit period on instance B.
        send(1, 8'h80);
        @(negedge clk); chk("b_latency_edgeN",  int'(ser_b), 1);
        @(negedge clk); chk("b_latency_edgeN1", int'(ser_b), 1);
        @(negedge clk); chk("b_latency_edgeN2", int'(ser_b), 0);
        wait_idle(1, 60);

        chk("leftover_a", exp_a.size(), 0);
        chk("leftover_b", exp_b.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the flight controller's UART link. It sends 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) with a fixed bit period of CLKS_PER_BIT clocks. Bytes are accepted through a valid/ready handshake into a small internal FIFO, so the host logic can queue telemetry without waiting for each frame to finish. Its line output drives the board TX pin, which the matching receiver on the far end samples.

## Interface
- CLKS_PER_BIT, default 2: clocks per serial bit; legal range 2..65535.
- FIFO_DEPTH, default 4: byte queue depth; must be a power of two, ≥2.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset; release is synchronous to clk.
- i_Tx_Valid  input  1  host presents a byte on i_Tx_Data.
- i_Tx_Data  input  8  byte to send.
- o_Tx_Ready  output  1  queue can accept a byte; equals !full.
- o_Tx_Serial  output  1  serial line, registered; idles high.
- o_Tx_Active  output  1  high while a frame is on the line (start through stop).
- o_Tx_Done  output  1  one-cycle pulse on the last clock of each stop bit.

## Operation
- Handshake: a byte is written on any rising edge with i_Tx_Valid && o_Tx_Ready. If i_Tx_Valid is high while full, nothing is written; i_Tx_Data may change freely.
- o_Tx_Ready is combinational from the occupancy count. A pop in the same cycle does not raise it early.
- Simultaneous push and pop when not full: both take effect and the count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: line high, counters zero. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: line low for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: line = shift[0] for CLKS_PER_BIT clocks, then shift right. After bit index 7, go to STOP.
  - STOP: line high for CLKS_PER_BIT clocks. On the last clock, pulse o_Tx_Done. On that same edge, go to START if the FIFO is non-empty (popping the next byte), otherwise go to IDLE.
- Bit counter is 16 bits and wraps to 0 at CLKS_PER_BIT-1. Bit index is 3 bits.
- Reset (at any time, including mid-frame): FSM to IDLE, FIFO emptied, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1. A truncated frame is simply abandoned, and the line returns high immediately.
- Unused state encodings go to IDLE with the line high.

## Timing
- Latency, empty queue: byte written at edge N, popped at edge N+1, o_Tx_Serial low after edge N+2.
- Frame length is exactly 10×CLKS_PER_BIT clocks.
- Back-to-back frames: no idle clock between the stop bit and the next start bit.
- o_Tx_Active is high from the first start-bit clock through the last stop-bit clock. It stays high across back-to-back frames.
- o_Tx_Done is high for one clock, aligned with the final stop-bit clock.
- Throughput: one byte per 10×CLKS_PER_BIT clocks. A FIFO_DEPTH burst is accepted in FIFO_DEPTH consecutive clocks from an empty queue.

## Structure
- Shared package uart_pkg holds:
  - the state localparams IDLE=0, START=1, DATA=2, STOP=3, so that the receiver and transmitter use matching encodings;
  - the frame constants (DATA_BITS=8, STOP_BITS=1).
- Sub-module uart_tx_fifo: synchronous FIFO, width 8, depth FIFO_DEPTH.
  - Ports: clk, rst_n, push, din, pop, dout, full, empty.
  - dout is the head (first-word fall-through).
  - Pointers are wrap-around modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits wide.
- Top level: FSM, bit counter, bit index, shift register, registered line output.

## Test plan
- Single byte, CLKS_PER_BIT=4: push 0xA5. Line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, 40 clocks total. o_Tx_Done pulses once, at clock 40 of the frame.
- Back-to-back: push 0x00 then 0xFF on consecutive clocks. Result is 80 contiguous clocks, o_Tx_Active never drops, and o_Tx_Done pulses at clocks 40 and 80.
- Full queue, FIFO_DEPTH=4: hold i_Tx_Valid for 6 clocks with data 0x01..0x06.
  - 0x01 pops, then 0x02..0x05 fill the queue, ready drops, and 0x06 is not written.
  - Exactly 0x01..0x05 are transmitted, in order.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x3C. Line goes high asynchronously, ready=1, and the queue is empty. After release, nothing is transmitted.
- Idle/reset values: after reset with no valid, line stays 1, Active=0, Done=0, Ready=1 for 100 clocks.
- CLKS_PER_BIT=2 minimum: push 0x80. Bits are 2 clocks each, 20-clock frame, and only bit 7 is high.
